// File: rtl/t04_mem_access_unit.sv
// t04_mem_access_unit
//   Multi-cycle load/store unit between the t04 datapath and the data-memory
//   bus. One load or store is accepted per request. It derives byte enables and
//   a word-aligned address from the low address bits, replicates store data
//   across lanes, and extracts and extends load data from the addressed lane.
//   It waits on mem_ack with an optional bounded timeout. Misaligned or illegal
//   accesses fault without reaching memory.
//
// Parameters
//   ADDR_W   address width (addr, addr_to_mem)
//   TIMEOUT  max ACCESS cycles without mem_ack before a fault; 0 = no timeout
//
// Ports
//   clk, nRst                    clock, synchronous active-low reset
//   req_read, req_write          load/store request, held until done
//   size[2:0]                    funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr, store_data             byte address, rs2 value
//   data_to_reg                  load result, valid while done=1
//   done, fault                  one-cycle retire pulse / fault pulse (with done)
//   stall                        (req_read|req_write) & ~done
//   mem_read, mem_write          registered bus strobes
//   addr_to_mem, data_to_mem     word address, lane-replicated store data
//   select[3:0]                  byte enables
//   mem_ack, data_from_mem       one-cycle acknowledge and read word
module t04_mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       data_to_reg,
    output logic              done,
    output logic              fault,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] addr_to_mem,
    output logic [31:0]       data_to_mem,
    output logic [3:0]        select,
    input  logic              mem_ack,
    input  logic [31:0]       data_from_mem
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value in the last strobe cycle before a timeout fault.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_read;
    logic [2:0]    size_q;
    logic [1:0]    off_q;

    logic          legal;
    logic [3:0]    sel_c;
    logic [31:0]   wdata_c;
    logic [31:0]   lane;
    logic [31:0]   load_c;

    assign stall = (req_read | req_write) & ~done;

    // Request decode. req_read wins when both requests are high.
    always_comb begin
        legal   = 1'b1;
        sel_c   = '0;
        wdata_c = store_data;
        case (size[1:0])
            2'b00: begin
                sel_c   = 4'b0001 << addr[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                sel_c   = 4'b0011 << addr[1:0];
                wdata_c = {2{store_data[15:0]}};
                if (addr[0]) legal = 1'b0;
            end
            2'b10: begin
                sel_c = 4'b1111;
                if (addr[1:0] != 2'b00) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        // Unsigned variants exist only for byte/halfword loads.
        if (size[2] && (!req_read || size[1])) legal = 1'b0;
    end

    // Load extraction from the lane latched at request time.
    always_comb begin
        lane = data_from_mem >> {off_q, 3'b000};
        case (size_q)
            3'b000:  load_c = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_c = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_c = {24'd0, lane[7:0]};
            3'b101:  load_c = {16'd0, lane[15:0]};
            default: load_c = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_read     <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            addr_to_mem <= '0;
            data_to_mem <= '0;
            select      <= '0;
            data_to_reg <= '0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_read || req_write) begin
                        op_read <= req_read;
                        size_q  <= size;
                        off_q   <= addr[1:0];
                        if (legal) begin
                            state       <= ACCESS;
                            cnt         <= '0;
                            mem_read    <= req_read;
                            mem_write   <= ~req_read;
                            addr_to_mem <= {addr[ADDR_W-1:2], 2'b00};
                            select      <= sel_c;
                            data_to_mem <= req_read ? '0 : wdata_c;
                        end else begin
                            state       <= FAULT;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            data_to_reg <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != '1) cnt <= cnt + CW'(1);
                    // Ack takes precedence over a timeout in the same cycle.
                    if (mem_ack) begin
                        state       <= RESP;
                        done        <= 1'b1;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        data_to_reg <= op_read ? load_c : '0;
                    end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                        state       <= FAULT;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        data_to_reg <= '0;
                    end
                end
                RESP, FAULT: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    fault       <= 1'b0;
                    data_to_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t04_mem_access_unit.sv
// Bench for t04_mem_access_unit with TIMEOUT=4. Directed scenarios follow the
// documented access examples; a randomized phase compares against a
// byte-arithmetic reference model.
module tb_t04_mem_access_unit;

    localparam int ADDR_W = 32;
    localparam int TMO    = 4;

    logic        clk = 1'b0;
    logic        nRst;
    logic        req_read, req_write;
    logic [2:0]  size;
    logic [31:0] addr, store_data, data_to_reg;
    logic        done, fault, stall, mem_read, mem_write;
    logic [31:0] addr_to_mem, data_to_mem;
    logic [3:0]  select;
    logic        mem_ack;
    logic [31:0] data_from_mem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    t04_mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .nRst(nRst), .req_read(req_read), .req_write(req_write),
        .size(size), .addr(addr), .store_data(store_data),
        .data_to_reg(data_to_reg), .done(done), .fault(fault), .stall(stall),
        .mem_read(mem_read), .mem_write(mem_write), .addr_to_mem(addr_to_mem),
        .data_to_mem(data_to_mem), .select(select), .mem_ack(mem_ack),
        .data_from_mem(data_from_mem)
    );

    // Observations of the most recent access driven by do_access.
    int          obs_done_cyc, obs_rd_cycles, obs_wr_cycles, obs_first_strobe, obs_stall_cycles;
    logic        obs_fault, obs_stall_at_done, obs_busy_after;
    logic [31:0] obs_data, obs_addr_mem, obs_wdata;
    logic [3:0]  obs_select;

    // ---------------- reference model ----------------
    function automatic int unsigned nbytes(input logic [2:0] sz);
        return 32'd1 << sz[1:0];
    endfunction

    function automatic logic ref_legal(input logic rd, input logic [2:0] sz, input logic [31:0] a);
        int unsigned n;
        if (rd) begin
            if (!(sz inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        end else begin
            if (!(sz inside {3'b000, 3'b001, 3'b010})) return 1'b0;
        end
        n = nbytes(sz);
        return ((a % n) == 0);
    endfunction

    function automatic logic [3:0] ref_select(input logic [2:0] sz, input logic [31:0] a);
        int unsigned n;
        n = nbytes(sz);
        return 4'(((32'd1 << n) - 32'd1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] sz, input logic [31:0] sd);
        int unsigned n;
        logic [31:0] r;
        n = nbytes(sz);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] w);
        int unsigned n;
        logic [31:0] v, mask;
        n    = nbytes(sz);
        v    = w >> (8 * (a % 4));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = v & mask;
        if (!sz[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic predict(input logic rd, input logic [2:0] sz, input logic [31:0] a,
                           input int ack_at, input logic [31:0] rdata,
                           output int e_done, output logic e_fault, output int e_strobes,
                           output logic [31:0] e_data);
        if (!ref_legal(rd, sz, a)) begin
            e_done = 1; e_fault = 1'b1; e_strobes = 0;
        end else if (ack_at >= 1 && ack_at <= TMO) begin
            e_done = ack_at + 1; e_fault = 1'b0; e_strobes = ack_at;
        end else begin
            e_done = TMO + 1; e_fault = 1'b1; e_strobes = TMO;
        end
        e_data = (!e_fault && rd) ? ref_load(sz, a, rdata) : 32'd0;
    endtask

    // ---------------- stimulus driver ----------------
    // Starts in an IDLE cycle (cycle 0), acks in cycle ack_at (0 = never),
    // drops the request once done is seen and returns in the following cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] sd,
                             input int ack_at, input logic [31:0] rdata);
        req_read = rd; req_write = wr; size = sz; addr = a; store_data = sd;
        mem_ack = 1'($urandom_range(0, 1));
        data_from_mem = $urandom;
        obs_done_cyc = -1; obs_rd_cycles = 0; obs_wr_cycles = 0; obs_first_strobe = -1;
        obs_fault = 1'b0; obs_data = '0; obs_stall_at_done = 1'b0;
        obs_select = '0; obs_addr_mem = '0; obs_wdata = '0;
        #1;
        obs_stall_cycles = stall ? 1 : 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (mem_read) obs_rd_cycles++;
            if (mem_write) obs_wr_cycles++;
            if ((mem_read || mem_write) && obs_first_strobe < 0) begin
                obs_first_strobe = cyc;
                obs_select = select; obs_addr_mem = addr_to_mem; obs_wdata = data_to_mem;
            end
            if (done) begin
                obs_done_cyc = cyc; obs_fault = fault; obs_data = data_to_reg;
                obs_stall_at_done = stall;
                break;
            end
            if (stall) obs_stall_cycles++;
            mem_ack = (cyc == ack_at);
            data_from_mem = (cyc == ack_at) ? rdata : $urandom;
        end
        if (obs_done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done within 30 cycles, expected done");
        end
        req_read = 1'b0; req_write = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        data_from_mem = $urandom;
        @(posedge clk); #1;
        obs_busy_after = done | fault | mem_read | mem_write;
        mem_ack = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nRst = 1'b0; req_read = 1'b1; req_write = 1'b0; size = 3'b010;
        addr = 32'h10; store_data = '0; mem_ack = 1'b1; data_from_mem = 32'hFFFF_FFFF;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if ({mem_read, mem_write, done, fault} !== 4'b0) begin errors++;
            $display("FAIL reset_flags: got %b expected 0000", {mem_read, mem_write, done, fault}); end
        checks++; if ({addr_to_mem, data_to_mem, data_to_reg, select} !== '0) begin errors++;
            $display("FAIL reset_data: got %h %h %h %b expected zeros", addr_to_mem, data_to_mem, data_to_reg, select); end
        req_read = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        nRst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL reset_stall: got %b expected 0", stall); end
    endtask

    task automatic test_lb();
        do_access(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 3, 32'h8011_2233);
        checks++; if (obs_select !== 4'b1000) begin errors++; $display("FAIL lb_select: got %b expected 1000", obs_select); end
        checks++; if (obs_addr_mem !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h expected 00001000", obs_addr_mem); end
        checks++; if (obs_first_strobe !== 1) begin errors++; $display("FAIL lb_first_strobe: got %0d expected 1", obs_first_strobe); end
        checks++; if (obs_rd_cycles !== 3 || obs_wr_cycles !== 0) begin errors++; $display("FAIL lb_strobes: got rd %0d wr %0d expected rd 3 wr 0", obs_rd_cycles, obs_wr_cycles); end
        checks++; if (obs_done_cyc !== 4) begin errors++; $display("FAIL lb_done_cycle: got %0d expected 4", obs_done_cyc); end
        checks++; if (obs_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", obs_data); end
        checks++; if (obs_fault !== 1'b0) begin errors++; $display("FAIL lb_fault: got %b expected 0", obs_fault); end
        checks++; if (obs_stall_cycles !== 4 || obs_stall_at_done !== 1'b0) begin errors++; $display("FAIL lb_stall: got %0d/%b expected 4/0", obs_stall_cycles, obs_stall_at_done); end
        checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL lb_after: got %b expected 0", obs_busy_after); end
    endtask

    task automatic test_lh_lhu();
        do_access(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 1, 32'h9ABC_0000);
        checks++; if (obs_select !== 4'b1100) begin errors++; $display("FAIL lhu_select: got %b expected 1100", obs_select); end
        checks++; if (obs_data !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_data: got %h expected 00009abc", obs_data); end
        checks++; if (obs_done_cyc !== 2) begin errors++; $display("FAIL lhu_done_cycle: got %0d expected 2", obs_done_cyc); end
        do_access(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 2, 32'h9ABC_0000);
        checks++; if (obs_data !== 32'hFFFF_9ABC) begin errors++; $display("FAIL lh_data: got %h expected ffff9abc", obs_data); end
        checks++; if (obs_done_cyc !== 3) begin errors++; $display("FAIL lh_done_cycle: got %0d expected 3", obs_done_cyc); end
    endtask

    task automatic test_sb();
        do_access(1'b0, 1'b1, 3'b000, 32'h0001, 32'hDEAD_BEEF, 2, 32'h1234_5678);
        checks++; if (obs_wr_cycles !== 2 || obs_rd_cycles !== 0) begin errors++; $display("FAIL sb_strobes: got rd %0d wr %0d expected rd 0 wr 2", obs_rd_cycles, obs_wr_cycles); end
        checks++; if (obs_select !== 4'b0010) begin errors++; $display("FAIL sb_select: got %b expected 0010", obs_select); end
        checks++; if (obs_wdata !== 32'hEFEF_EFEF) begin errors++; $display("FAIL sb_wdata: got %h expected efefefef", obs_wdata); end
        checks++; if (obs_done_cyc !== 3 || obs_data !== 32'd0) begin errors++; $display("FAIL sb_done: got cyc %0d data %h expected cyc 3 data 0", obs_done_cyc, obs_data); end
    endtask

    task automatic test_faults();
        logic        rd_t [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0]  sz_t [3] = '{3'b010, 3'b001, 3'b111};
        logic [31:0] a_t  [3] = '{32'h6, 32'h1, 32'h40};
        for (int i = 0; i < 3; i++) begin
            do_access(rd_t[i], ~rd_t[i], sz_t[i], a_t[i], 32'hCAFE_F00D, 1, 32'h5555_AAAA);
            checks++; if (obs_done_cyc !== 1 || obs_fault !== 1'b1) begin errors++;
                $display("FAIL fault%0d_resp: got cyc %0d fault %b expected cyc 1 fault 1", i, obs_done_cyc, obs_fault); end
            checks++; if (obs_rd_cycles + obs_wr_cycles !== 0) begin errors++;
                $display("FAIL fault%0d_strobe: got %0d strobe cycles expected 0", i, obs_rd_cycles + obs_wr_cycles); end
            checks++; if (obs_data !== 32'd0) begin errors++;
                $display("FAIL fault%0d_data: got %h expected 0", i, obs_data); end
        end
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'h0);
        checks++; if (obs_rd_cycles !== 4 || obs_first_strobe !== 1) begin errors++; $display("FAIL timeout_strobe: got %0d from %0d expected 4 from 1", obs_rd_cycles, obs_first_strobe); end
        checks++; if (obs_done_cyc !== 5 || obs_fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got cyc %0d fault %b expected cyc 5 fault 1", obs_done_cyc, obs_fault); end
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 4, 32'h0BAD_CAFE);
        checks++; if (obs_done_cyc !== 5 || obs_fault !== 1'b0) begin errors++; $display("FAIL late_ack: got cyc %0d fault %b expected cyc 5 fault 0", obs_done_cyc, obs_fault); end
        checks++; if (obs_data !== 32'h0BAD_CAFE) begin errors++; $display("FAIL late_ack_data: got %h expected 0badcafe", obs_data); end
    endtask

    task automatic test_priority();
        do_access(1'b1, 1'b1, 3'b010, 32'h3000, 32'h55, 2, 32'h1234_5678);
        checks++; if (obs_rd_cycles !== 2 || obs_wr_cycles !== 0) begin errors++; $display("FAIL prio_strobes: got rd %0d wr %0d expected rd 2 wr 0", obs_rd_cycles, obs_wr_cycles); end
        checks++; if (obs_data !== 32'h1234_5678) begin errors++; $display("FAIL prio_data: got %h expected 12345678", obs_data); end
    endtask

    task automatic test_back_to_back();
        req_read = 1'b1; req_write = 1'b0; size = 3'b010; addr = 32'h44; mem_ack = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL b2b_strobe1: got %b expected 1", mem_read); end
        mem_ack = 1'b1; data_from_mem = 32'hA5A5_0001;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || data_to_reg !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_done1: got %b %h expected 1 a5a50001", done, data_to_reg); end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_read !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b %b expected 0 0", mem_read, done); end
        @(posedge clk); #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL b2b_reissue: got %b expected 1", mem_read); end
        mem_ack = 1'b1; data_from_mem = 32'h5A5A_0002;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || data_to_reg !== 32'h5A5A_0002) begin errors++; $display("FAIL b2b_done2: got %b %h expected 1 5a5a0002", done, data_to_reg); end
        req_read = 1'b0; mem_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (mem_read !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_quiet: got %b %b expected 0 0", mem_read, done); end
    endtask

    task automatic test_reset_mid_access();
        req_read = 1'b1; req_write = 1'b0; size = 3'b010; addr = 32'h100; mem_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b expected 1", mem_read); end
        nRst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({mem_read, mem_write, done, fault, select} !== '0 || addr_to_mem !== '0) begin errors++;
            $display("FAIL rst_mid_outputs: got %b%b%b%b %b %h expected zeros", mem_read, mem_write, done, fault, select, addr_to_mem); end
        nRst = 1'b1; req_read = 1'b0; mem_ack = 1'b1; data_from_mem = 32'h1111_2222;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            checks++; if (done !== 1'b0 || mem_read !== 1'b0) begin errors++;
                $display("FAIL rst_mid_ack%0d: got done %b rd %b expected 0 0", c, done, mem_read); end
        end
    endtask

    task automatic test_random();
        int          e_done, e_strobes, ack_at, op;
        logic        e_fault, rd, wr;
        logic [2:0]  sz;
        logic [31:0] a, sd, rdata, e_data;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 2);
            rd = (op != 1); wr = (op != 0);
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) sz = 3'b010;
            a = $urandom; sd = $urandom; rdata = $urandom;
            ack_at = $urandom_range(0, TMO + 2);
            predict(rd, sz, a, ack_at, rdata, e_done, e_fault, e_strobes, e_data);
            do_access(rd, wr, sz, a, sd, ack_at, rdata);
            checks++; if (obs_done_cyc !== e_done) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d expected %0d", i, obs_done_cyc, e_done); end
            checks++; if (obs_fault !== e_fault) begin errors++; $display("FAIL rnd%0d_fault: got %b expected %b", i, obs_fault, e_fault); end
            checks++; if (obs_data !== e_data) begin errors++; $display("FAIL rnd%0d_data: got %h expected %h", i, obs_data, e_data); end
            checks++; if (obs_rd_cycles !== (rd ? e_strobes : 0) || obs_wr_cycles !== (rd ? 0 : e_strobes)) begin errors++;
                $display("FAIL rnd%0d_strobes: got rd %0d wr %0d expected %0d on %s", i, obs_rd_cycles, obs_wr_cycles, e_strobes, rd ? "read" : "write"); end
            checks++; if (obs_stall_cycles !== e_done || obs_stall_at_done !== 1'b0) begin errors++;
                $display("FAIL rnd%0d_stall: got %0d/%b expected %0d/0", i, obs_stall_cycles, obs_stall_at_done, e_done); end
            checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_after: got %b expected 0", i, obs_busy_after); end
            if (e_strobes > 0) begin
                checks++; if (obs_select !== ref_select(sz, a)) begin errors++; $display("FAIL rnd%0d_select: got %b expected %b", i, obs_select, ref_select(sz, a)); end
                checks++; if (obs_addr_mem !== (a & ~32'd3)) begin errors++; $display("FAIL rnd%0d_addr: got %h expected %h", i, obs_addr_mem, a & ~32'd3); end
                if (!rd) begin
                    checks++; if (obs_wdata !== ref_wdata(sz, sd)) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", i, obs_wdata, ref_wdata(sz, sd)); end
                end
            end
        end
    endtask

    initial begin
        nRst = 1'b0; req_read = 1'b0; req_write = 1'b0; size = '0; addr = '0;
        store_data = '0; mem_ack = 1'b0; data_from_mem = '0;
        #1;
        test_reset();
        test_lb();
        test_lh_lhu();
        test_sb();
        test_faults();
        test_timeout();
        test_priority();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 ns, expected finish");
        $fatal(1);
    end

endmodule
